// File: rtl/i2s_rx_pkg.sv
// Shared types for the I2S receiver.
//   i2s_rx_state_t : receiver framing state (HUNT / LEFT / RIGHT)
//   SAMPLE_W       : output sample width
//   sample_t       : signed output sample
//   sample_mag()   : |sample| as 15 bits, -32768 saturating to 32767
package i2s_pkg;

  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} i2s_rx_state_t;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic logic [SAMPLE_W-2:0] sample_mag(input sample_t s);
    logic [SAMPLE_W-1:0] m;
    m = s[SAMPLE_W-1] ? SAMPLE_W'(~s + 16'sd1) : SAMPLE_W'(s);
    // Only the most negative value still has the top bit set after negation.
    if (m[SAMPLE_W-1]) return '1;
    return m[SAMPLE_W-2:0];
  endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Synchroniser for the three asynchronous I2S lines plus BCK rise detection.
// Ports:
//   clk_sys, reset          : system clock, synchronous active-high reset
//   bck, lrck, data         : raw codec lines
//   lrck_sync, data_sync    : synchronised LRCK / DATA, aligned with bck_rise
//   bck_rise                : one-cycle pulse on synchronised BCK 0->1
// SYNC_STAGES must be at least 2.
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic bck,
  input  logic lrck,
  input  logic data,
  output logic lrck_sync,
  output logic data_sync,
  output logic bck_rise
);

  // All three lines travel through the same depth so LRCK/DATA line up with BCK.
  logic [SYNC_STAGES-1:0][2:0] pipe;
  logic                        bck_prev;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pipe     <= '0;
      bck_prev <= 1'b0;
    end else begin
      pipe     <= {pipe[SYNC_STAGES-2:0], {data, lrck, bck}};
      bck_prev <= pipe[SYNC_STAGES-1][0];
    end
  end

  assign lrck_sync = pipe[SYNC_STAGES-1][1];
  assign data_sync = pipe[SYNC_STAGES-1][2];
  assign bck_rise  = pipe[SYNC_STAGES-1][0] & ~bck_prev;

endmodule

// File: rtl/i2s_rx.sv
// Slave-mode I2S receiver: deserialises codec BCK/LRCK/DATA into 16-bit signed
// left/right sample pairs in the clk_sys domain. The core never drives BCK/LRCK.
// Ports:
//   clk_sys, reset              : system clock, synchronous active-high reset
//   i2s_bck, i2s_lrck, i2s_data : async codec lines (LRCK 0=left, 1=right)
//   left_chan, right_chan       : last complete sample pair
//   sample_valid                : 1-cycle strobe when the pair updates
//   short_err                   : sticky, some slot had fewer than 16 bits
//   err_clr                     : clears short_err (and peaks)
//   peak_l, peak_r              : max |sample| since reset/err_clr
//                                 (only when I2S_RX_PEAK_EN is defined)
// Optional feature macro: I2S_RX_PEAK_EN.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_SLOT    = 32
) (
  input  logic    clk_sys,
  input  logic    reset,
  input  logic    i2s_bck,
  input  logic    i2s_lrck,
  input  logic    i2s_data,
  input  logic    err_clr,
  output sample_t left_chan,
  output sample_t right_chan,
  output logic    sample_valid,
  output logic    short_err
`ifdef I2S_RX_PEAK_EN
  ,
  output logic [SAMPLE_W-2:0] peak_l,
  output logic [SAMPLE_W-2:0] peak_r
`endif
);

  localparam int CNT_W = $clog2(MAX_SLOT);

  logic lrck_s, data_s, bck_rise;

  i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bck       (i2s_bck),
    .lrck      (i2s_lrck),
    .data      (i2s_data),
    .lrck_sync (lrck_s),
    .data_sync (data_s),
    .bck_rise  (bck_rise)
  );

  i2s_rx_state_t    state;
  logic [CNT_W-1:0] bitcnt;
  sample_t          word;
  sample_t          hold;
  logic             lr_prev;

  logic             slot_end;
  logic             store_bit;
  logic             slot_short;
  logic [3:0]       bit_pos;
  sample_t          word_fin;

  // An LRCK change seen on a BCK rise means this bit is the last of the old slot.
  assign slot_end   = (lrck_s != lr_prev);
  assign store_bit  = int'(bitcnt) < SAMPLE_W;
  // bitcnt counts bits already taken, so the finished slot holds bitcnt+1 bits.
  assign slot_short = int'(bitcnt) < SAMPLE_W - 1;
  assign bit_pos    = 4'(SAMPLE_W - 1) - bitcnt[3:0];

  // Current word with the present bit merged in; bits beyond 16 are dropped.
  always_comb begin
    word_fin = word;
    if (store_bit) word_fin[bit_pos] = data_s;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= HUNT;
      bitcnt       <= '0;
      word         <= '0;
      hold         <= '0;
      lr_prev      <= 1'b0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      short_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (err_clr) short_err <= 1'b0;
      if (bck_rise) begin
        if (slot_end) begin
          word    <= '0;
          bitcnt  <= '0;
          lr_prev <= lrck_s;
          case (state)
            HUNT: begin
              // Only a left-slot start guarantees a whole L+R pair follows.
              if (!lrck_s) state <= LEFT;
            end
            LEFT: begin
              hold  <= word_fin;
              state <= RIGHT;
              if (slot_short) short_err <= 1'b1;
            end
            RIGHT: begin
              left_chan    <= hold;
              right_chan   <= word_fin;
              sample_valid <= 1'b1;
              state        <= LEFT;
              if (slot_short) short_err <= 1'b1;
            end
            default: state <= HUNT;
          endcase
        end else begin
          word <= word_fin;
          if (int'(bitcnt) < MAX_SLOT - 1) bitcnt <= bitcnt + 1'b1;
        end
      end
    end
  end

`ifdef I2S_RX_PEAK_EN
  logic [SAMPLE_W-2:0] mag_l, mag_r;

  assign mag_l = sample_mag(left_chan);
  assign mag_r = sample_mag(right_chan);

  always_ff @(posedge clk_sys) begin
    if (reset || err_clr) begin
      peak_l <= '0;
      peak_r <= '0;
    end else if (sample_valid) begin
      if (mag_l > peak_l) peak_l <= mag_l;
      if (mag_r > peak_r) peak_r <= mag_r;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: BCK = clk_sys/8, bit-level I2S stream driven from
// slot descriptions; a slot-level model predicts each output pair.
module tb_i2s_rx;

  logic        clk_sys = 1'b0;
  logic        reset, i2s_bck, i2s_lrck, i2s_data, err_clr;
  logic [15:0] left_chan, right_chan;
  logic        sample_valid, short_err;
`ifdef I2S_RX_PEAK_EN
  logic [14:0] peak_l, peak_r;
`endif

  i2s_rx dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .i2s_bck      (i2s_bck),
    .i2s_lrck     (i2s_lrck),
    .i2s_data     (i2s_data),
    .err_clr      (err_clr),
    .left_chan    (left_chan),
    .right_chan   (right_chan),
    .sample_valid (sample_valid),
    .short_err    (short_err)
`ifdef I2S_RX_PEAK_EN
    ,
    .peak_l       (peak_l),
    .peak_r       (peak_r)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        sh;
    int          at;
    logic [14:0] pl;
    logic [14:0] pr;
  } exp_t;

  exp_t q[$];

  // slot-level model state
  bit          lr_known, cur_chan, in_frame, have_left, left_sh, sticky;
  bit          prev_last = 1'b0;
  logic [15:0] left_exp;
  logic [14:0] mpl, mpr;
  logic [31:0] cur_w;
  int          cur_n;
  int          widths[7] = '{8, 12, 15, 16, 17, 24, 32};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Take the top 16 bits of an n-bit MSB-first word, zero-padding short words.
  function automatic logic [15:0] align16(input logic [31:0] w, input int n);
    if (n >= 16) return 16'(w >> (n - 16));
    return 16'(w << (16 - n));
  endfunction

  function automatic logic [14:0] mag(input logic [15:0] v);
    int s, a;
    s = int'($signed(v));
    a = (s < 0) ? -s : s;
    if (a > 32767) a = 32767;
    return 15'(a);
  endfunction

  task automatic model_reset();
    lr_known  = 0;
    in_frame  = 0;
    have_left = 0;
    sticky    = 0;
    mpl       = '0;
    mpr       = '0;
  endtask

  // First BCK rise of a new slot on channel c: the previous slot is now complete.
  task automatic slot_start(input bit c, input int rise_cyc);
    logic [15:0] v;
    bit          s;
    exp_t        e;
    if (lr_known && cur_chan != c) begin
      v = align16(cur_w, cur_n);
      s = (cur_n < 16);
      if (cur_chan == 1'b0) begin
        if (in_frame) begin
          have_left = 1;
          left_exp  = v;
          left_sh   = s;
          if (s) sticky = 1;
        end
      end else if (have_left) begin
        if (s) sticky = 1;
        if (mag(left_exp) > mpl) mpl = mag(left_exp);
        if (mag(v) > mpr) mpr = mag(v);
        e.l  = left_exp;
        e.r  = v;
        e.sh = sticky;
        e.at = rise_cyc + 3;
        e.pl = mpl;
        e.pr = mpr;
        q.push_back(e);
        have_left = 0;
      end
      if (c == 1'b0) in_frame = 1;
    end
    lr_known = 1;
    cur_chan = c;
  endtask

  // Drive one slot of n bits; each rise carries the previous bit (1-bit delay).
  task automatic emit_slot(input bit c, input logic [31:0] w, input int n);
    bit d;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? prev_last : w[n - i];
      i2s_bck  = 1'b0;
      i2s_lrck = c;
      i2s_data = d;
      repeat (4) @(posedge clk_sys);
      #1;
      i2s_bck = 1'b1;
      if (i == 0) slot_start(c, cyc);
      repeat (4) @(posedge clk_sys);
      #1;
    end
    cur_w     = w;
    cur_n     = n;
    prev_last = w[0];
  endtask

  task automatic do_reset();
    i2s_bck = 1'b0;
    reset   = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk_sys);
    #1;
    err_clr = 1'b0;
    sticky  = 0;
    mpl     = '0;
    mpr     = '0;
  endtask

  task automatic lead_in();
    emit_slot(1'b1, 32'h5, 3);
  endtask

  task automatic trail();
    emit_slot(1'b0, 32'h0, 1);
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  // monitor
  exp_t mon_e;
  exp_t peak_e;
  bit   peak_due = 0;

  always @(negedge clk_sys) begin
    if (!reset) begin
`ifdef I2S_RX_PEAK_EN
      if (peak_due) begin
        chk("peak_l", 32'(peak_l), 32'(peak_e.pl));
        chk("peak_r", 32'(peak_r), 32'(peak_e.pr));
        peak_due = 0;
      end
`endif
      if (sample_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_valid: got sample_valid=1 expected 0 at cycle %0d", cyc);
        end else begin
          mon_e = q.pop_front();
          chk("left_chan", 32'(left_chan), 32'(mon_e.l));
          chk("right_chan", 32'(right_chan), 32'(mon_e.r));
          chk("short_err_at_valid", 32'(short_err), 32'(mon_e.sh));
          chk("valid_cycle", 32'(cyc), 32'(mon_e.at));
          peak_e   = mon_e;
          peak_due = 1;
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    int          n;
    reset    = 1'b1;
    err_clr  = 1'b0;
    i2s_bck  = 1'b0;
    i2s_lrck = 1'b0;
    i2s_data = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    model_reset();

    // idle after reset
    repeat (100) @(posedge clk_sys);
    #1;
    chk("idle_left", 32'(left_chan), 32'h0);
    chk("idle_right", 32'(right_chan), 32'h0);
    chk("idle_short", 32'(short_err), 32'h0);
    chk("idle_valid", 32'(sample_valid), 32'h0);
`ifdef I2S_RX_PEAK_EN
    chk("idle_peak_l", 32'(peak_l), 32'h0);
`endif

    // basic 16-bit frame
    lead_in();
    emit_slot(1'b0, 32'h1234, 16);
    emit_slot(1'b1, 32'hABCD, 16);
    trail();
    chk("frame16_short", 32'(short_err), 32'h0);
    chk("frame16_hold_left", 32'(left_chan), 32'h1234);

    // 24-bit slots truncate
    do_reset();
    lead_in();
    emit_slot(1'b0, 32'h123456, 24);
    emit_slot(1'b1, 32'h89ABCD, 24);
    trail();
    chk("frame24_right", 32'(right_chan), 32'h89AB);

    // 8-bit slots pad and set short_err; err_clr; set again
    do_reset();
    lead_in();
    emit_slot(1'b0, 32'hA5, 8);
    emit_slot(1'b1, 32'h5A, 8);
    emit_slot(1'b0, 32'hA5, 8);
    chk("short8_set", 32'(short_err), 32'h1);
    pulse_clr();
    chk("short8_cleared", 32'(short_err), 32'h0);
    emit_slot(1'b1, 32'h5A, 8);
    trail();
    chk("short8_set_again", 32'(short_err), 32'h1);

    // stream starts mid right slot
    do_reset();
    emit_slot(1'b1, 32'h3F, 6);
    emit_slot(1'b0, 32'($urandom_range(0, 65535)), 16);
    emit_slot(1'b1, 32'($urandom_range(0, 65535)), 16);
    trail();

    // reset mid left slot, then a clean frame
    do_reset();
    lead_in();
    emit_slot(1'b0, 32'hFF, 8);
    do_reset();
    lead_in();
    emit_slot(1'b0, 32'h0001, 16);
    emit_slot(1'b1, 32'hFFFF, 16);
    trail();
    chk("after_reset_left", 32'(left_chan), 32'h0001);
    chk("after_reset_right", 32'(right_chan), 32'hFFFF);

`ifdef I2S_RX_PEAK_EN
    do_reset();
    lead_in();
    emit_slot(1'b0, 32'h8000, 16);
    emit_slot(1'b1, 32'h0000, 16);
    emit_slot(1'b0, 32'h0100, 16);
    emit_slot(1'b1, 32'h0000, 16);
    emit_slot(1'b0, 32'h0100, 16);
    chk("peak_held", 32'(peak_l), 32'h7FFF);
    pulse_clr();
    chk("peak_cleared", 32'(peak_l), 32'h0);
    emit_slot(1'b1, 32'h0000, 16);
    trail();
    chk("peak_after_clr", 32'(peak_l), 32'h0100);
`endif

    // randomized frames of mixed slot widths
    do_reset();
    lead_in();
    for (int f = 0; f < 20; f++) begin
      for (int c = 0; c < 2; c++) begin
        n = widths[$urandom_range(0, 6)];
        w = $urandom;
        if (n < 32) w = w & ((32'd1 << n) - 32'd1);
        emit_slot(c[0], w, n);
      end
    end
    trail();

    repeat (8) @(posedge clk_sys);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
